cvxif_result_scheduler: RTL and testbench

// - Shares the single CV-X-IF result port between two producers in the example coprocessor:
//   - same-cycle pick/fill results ("imm");
//   - long-latency exec completions ("exec", an un-stallable pulse from the groups datapath).
// - Buffers results in an in-order FIFO so result_ready may be deasserted.
// - Throttles exec launch with credits so an exec completion always finds a free slot.

---
 rtl/cvxif_instr_pkg.sv | 14 +
 rtl/cvxif_result_fifo.sv | 53 +++++
 rtl/cvxif_result_scheduler.sv | 139 +++++++++++++
 tb/tb_cvxif_result_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_instr_pkg.sv
// Shared types and sizing constants for the example coprocessor's result path.
package cvxif_instr_pkg;

  localparam int unsigned XIdWidth       = 4;
  localparam int unsigned SchedDataWidth = 64;
  localparam int unsigned SchedDepth     = 4;

  typedef struct packed {
    logic [XIdWidth-1:0]       id;
    logic [SchedDataWidth-1:0] data;
    logic                      we;
  } sched_entry_t;

endpackage

// File: rtl/cvxif_result_fifo.sv
// In-order result FIFO: up to two writes and one read per cycle, with occupancy output.
module cvxif_result_fifo
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned Depth   = SchedDepth,
  parameter type         entry_t = sched_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr0_en,
  input  entry_t                 wr0_data,
  input  logic                   wr1_en,
  input  entry_t                 wr1_data,
  input  logic                   rd_en,
  output entry_t                 rd_data,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem [Depth];
  logic [PtrW-1:0]   rd_ptr_reg;
  logic [PtrW-1:0]   wr_ptr_reg;
  logic [CntW-1:0]   count_reg;
  logic [PtrW-1:0]   slot1;
  logic [PtrW-1:0]   wr_inc;

  // The second write lands right after the first one, or at wr_ptr if the first is idle.
  assign slot1  = wr_ptr_reg + PtrW'(wr0_en);
  assign wr_inc = PtrW'(wr0_en) + PtrW'(wr1_en);

  always_ff @(posedge clk_i) begin
    if (wr0_en) mem[wr_ptr_reg] <= wr0_data;
    if (wr1_en) mem[slot1]      <= wr1_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg + PtrW'(rd_en);
      wr_ptr_reg <= wr_ptr_reg + wr_inc;
      count_reg  <= count_reg + CntW'(wr0_en) + CntW'(wr1_en) - CntW'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/cvxif_result_scheduler.sv
// Merges immediate and exec results onto the single CV-X-IF result port, with
// credit-based exec throttling so an exec completion always has a FIFO slot.
module cvxif_result_scheduler
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned IdWidth   = XIdWidth,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = SchedDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 exec_start_i,
  output logic                 exec_allow_o,
  input  logic                 exec_done_i,
  input  logic [IdWidth-1:0]   exec_id_i,
  input  logic [DataWidth-1:0] exec_data_i,
  input  logic                 imm_valid_i,
  output logic                 imm_ready_o,
  input  logic [IdWidth-1:0]   imm_id_i,
  input  logic [DataWidth-1:0] imm_data_i,
  input  logic                 imm_we_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [IdWidth-1:0]   result_id_o,
  output logic [DataWidth-1:0] result_data_o,
  output logic                 result_we_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic                 we;
  } entry_t;

  logic [CntW-1:0] occ;
  logic [CntW-1:0] pend_reg;
  logic [CntW-1:0] pend_next;
  logic [CntW-1:0] free;
  logic            start_ok;
  logic            done_ok;
  logic            bypass_ok;
  logic            imm_acc;
  logic            fifo_empty;

  entry_t exec_entry;
  entry_t imm_entry;
  entry_t head;
  entry_t out_entry;
  entry_t last_reg;

  logic   wr0_en;
  logic   wr1_en;
  entry_t wr0_data;
  entry_t wr1_data;
  logic   rd_en;

  assign exec_entry = '{id: exec_id_i, data: exec_data_i, we: 1'b1};
  assign imm_entry  = '{id: imm_id_i, data: imm_data_i, we: imm_we_i};

  // Every reserved or occupied slot counts against capacity.
  assign free         = CntW'(Depth) - occ - pend_reg;
  assign fifo_empty   = (occ == '0);
  assign exec_allow_o = (free != '0);

  // Illegal pulses are dropped so the counters never wrap.
  assign start_ok  = exec_start_i & exec_allow_o;
  assign done_ok   = exec_done_i & (pend_reg != '0);
  assign pend_next = pend_reg + CntW'(start_ok) - CntW'(done_ok);

  assign bypass_ok   = fifo_empty & ~exec_done_i & result_ready_i;
  assign imm_ready_o = ((free - CntW'(start_ok)) != '0) | bypass_ok;
  assign imm_acc     = imm_valid_i & imm_ready_o;

  assign result_valid_o = ~fifo_empty | done_ok | imm_acc;
  assign rd_en          = ~fifo_empty & result_ready_i;

  // Source select: queued head first, then a live exec pulse, then imm. Whatever is
  // not driven out and consumed this cycle is queued, exec ahead of imm.
  always_comb begin
    out_entry = last_reg;
    wr0_en    = 1'b0;
    wr1_en    = 1'b0;
    wr0_data  = exec_entry;
    wr1_data  = imm_entry;
    if (!fifo_empty) begin
      out_entry = head;
      wr0_en    = done_ok;
      wr1_en    = imm_acc;
    end else if (done_ok) begin
      out_entry = exec_entry;
      wr0_en    = ~result_ready_i;
      wr1_en    = imm_acc;
    end else if (imm_acc) begin
      out_entry = imm_entry;
      wr1_en    = ~result_ready_i;
    end
  end

  cvxif_result_fifo #(
    .Depth   (Depth),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_data (wr1_data),
    .rd_en    (rd_en),
    .rd_data  (head),
    .count    (occ)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_reg <= '0;
      last_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      if (result_valid_o) last_reg <= out_entry;
    end
  end

  assign result_id_o   = out_entry.id;
  assign result_data_o = out_entry.data;
  assign result_we_o   = out_entry.we;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(exec_done_i && pend_reg == '0))
        else $warning("exec_done with no outstanding exec; pulse dropped");
      assert (!(exec_start_i && !exec_allow_o))
        else $warning("exec_start without a free credit; start ignored");
    end
  end

endmodule

// File: tb/tb_cvxif_result_scheduler.sv
// Directed bench for cvxif_result_scheduler with a scoreboard of expected results.
module tb_cvxif_result_scheduler;

  localparam int unsigned IdW = 4;
  localparam int unsigned DW  = 64;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [DW-1:0]  data;
    logic           we;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          exec_start_i;
  logic          exec_allow_o;
  logic          exec_done_i;
  logic [IdW-1:0] exec_id_i;
  logic [DW-1:0] exec_data_i;
  logic          imm_valid_i;
  logic          imm_ready_o;
  logic [IdW-1:0] imm_id_i;
  logic [DW-1:0] imm_data_i;
  logic          imm_we_i;
  logic          result_valid_o;
  logic          result_ready_i;
  logic [IdW-1:0] result_id_o;
  logic [DW-1:0] result_data_o;
  logic          result_we_o;

  always #5 clk_i = ~clk_i;

  cvxif_result_scheduler dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .exec_start_i   (exec_start_i),
    .exec_allow_o   (exec_allow_o),
    .exec_done_i    (exec_done_i),
    .exec_id_i      (exec_id_i),
    .exec_data_i    (exec_data_i),
    .imm_valid_i    (imm_valid_i),
    .imm_ready_o    (imm_ready_o),
    .imm_id_i       (imm_id_i),
    .imm_data_i     (imm_data_i),
    .imm_we_i       (imm_we_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_data_o  (result_data_o),
    .result_we_o    (result_we_o)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pay(input string tag, input exp_t obs, input exp_t exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t cur_out();
    return '{id: result_id_o, data: result_data_o, we: result_we_o};
  endfunction

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  logic stall_q   = 1'b0;
  exp_t stall_pay = '0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check_bit("stall_valid", result_valid_o, 1'b1);
        check_pay("stall_payload", cur_out(), stall_pay);
      end
      if (result_valid_o && result_ready_i) begin
        tests_run++;
        assert (sb.size() != 0) else begin
          tests_failed++;
          $error("FAIL sb_unexpected observed id=%0d expected no result", result_id_o);
        end
        if (sb.size() != 0) check_pay("sb_payload", cur_out(), sb.pop_front());
      end
      stall_q   <= result_valid_o && !result_ready_i;
      stall_pay <= cur_out();
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Settle combinational outputs, then record what the DUT must eventually emit.
  task automatic settle_push();
    #1;
    if (exec_done_i) sb.push_back('{id: exec_id_i, data: exec_data_i, we: 1'b1});
    if (imm_valid_i && imm_ready_o) sb.push_back('{id: imm_id_i, data: imm_data_i, we: imm_we_i});
  endtask

  task automatic clear_inputs();
    exec_start_i = 1'b0;
    exec_done_i  = 1'b0;
    exec_id_i    = '0;
    exec_data_i  = '0;
    imm_valid_i  = 1'b0;
    imm_id_i     = '0;
    imm_data_i   = '0;
    imm_we_i     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned drain_ids [4];

    rst_i          = 1'b1;
    result_ready_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      #1;
      check_bit("idle_valid", result_valid_o, 1'b0);
      check_bit("idle_allow", exec_allow_o, 1'b1);
      check_bit("idle_imm_ready", imm_ready_o, 1'b1);
      tick();
    end

    // imm bypass
    imm_valid_i = 1'b1; imm_id_i = 4'd2; imm_data_i = 64'h55; imm_we_i = 1'b1;
    settle_push();
    check_bit("byp_valid", result_valid_o, 1'b1);
    check_val("byp_id", 32'(result_id_o), 2);
    check_pay("byp_payload", cur_out(), '{id: 4'd2, data: 64'h55, we: 1'b1});
    tick();
    clear_inputs();
    #1;
    check_bit("byp_empty_after", result_valid_o, 1'b0);
    check_val("hold_id", 32'(result_id_o), 2);
    tick();

    // Simultaneous exec and imm into an empty FIFO
    exec_start_i = 1'b1;
    #1;
    check_bit("sim_allow", exec_allow_o, 1'b1);
    tick();
    clear_inputs();
    exec_done_i = 1'b1; exec_id_i = 4'd1; exec_data_i = 64'hA;
    imm_valid_i = 1'b1; imm_id_i = 4'd3; imm_data_i = 64'h33; imm_we_i = 1'b0;
    settle_push();
    check_bit("sim_imm_ready", imm_ready_o, 1'b1);
    check_val("sim_id_t0", 32'(result_id_o), 1);
    check_bit("sim_we_t0", result_we_o, 1'b1);
    tick();
    clear_inputs();
    #1;
    check_bit("sim_valid_t1", result_valid_o, 1'b1);
    check_val("sim_id_t1", 32'(result_id_o), 3);
    check_bit("sim_we_t1", result_we_o, 1'b0);
    tick();
    #1;
    check_bit("sim_empty_t2", result_valid_o, 1'b0);
    tick();

    // Back-pressure: fill with imm while ready is low
    result_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imm_valid_i = 1'b1;
      imm_id_i    = IdW'(4 + i);
      imm_data_i  = 64'h1000 + 64'(i);
      imm_we_i    = i[0];
      settle_push();
      check_bit("bp_imm_ready", imm_ready_o, i < 4);
      check_bit("bp_allow", exec_allow_o, i < 4);
      check_bit("bp_valid", result_valid_o, 1'b1);
      check_val("bp_head_id", 32'(result_id_o), 4);
      tick();
    end
    clear_inputs();
    #1;
    tick();
    result_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_bit("bp_drain_valid", result_valid_o, 1'b1);
      check_val("bp_drain_id", 32'(result_id_o), 32'(4 + k));
      tick();
    end
    #1;
    check_bit("bp_drained", result_valid_o, 1'b0);
    tick();

    // Credit reservation
    result_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exec_start_i = 1'b1;
      #1;
      check_bit("cr_allow", exec_allow_o, 1'b1);
      tick();
    end
    exec_start_i = 1'b0;
    imm_valid_i = 1'b1; imm_id_i = 4'd9; imm_data_i = 64'h99; imm_we_i = 1'b1;
    settle_push();
    check_bit("cr_imm_last_slot", imm_ready_o, 1'b1);
    tick();
    imm_id_i = 4'd10; imm_data_i = 64'hAA;
    settle_push();
    check_bit("cr_full_allow", exec_allow_o, 1'b0);
    check_bit("cr_full_imm_ready", imm_ready_o, 1'b0);
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      exec_done_i = 1'b1;
      exec_id_i   = IdW'(11 + k);
      exec_data_i = 64'hE0 + 64'(k);
      settle_push();
      check_val("cr_head_id", 32'(result_id_o), 9);
      tick();
    end
    clear_inputs();
    #1;
    check_bit("cr_occ4_allow", exec_allow_o, 1'b0);
    check_bit("cr_occ4_imm_ready", imm_ready_o, 1'b0);
    check_bit("cr_occ4_valid", result_valid_o, 1'b1);
    tick();
    result_ready_i = 1'b1;
    drain_ids = '{9, 11, 12, 13};
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("cr_drain_id", 32'(result_id_o), drain_ids[k]);
      tick();
    end
    #1;
    check_bit("cr_drained", result_valid_o, 1'b0);
    check_bit("cr_allow_back", exec_allow_o, 1'b1);
    tick();

    // Reset mid-drain with occ=3, pend=1
    result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exec_start_i = 1'b1;
      tick();
    end
    exec_start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exec_done_i = 1'b1;
      exec_id_i   = IdW'(1 + k);
      exec_data_i = 64'h200 + 64'(k);
      settle_push();
      tick();
    end
    clear_inputs();
    #1;
    check_bit("rst_pre_allow", exec_allow_o, 1'b0);
    rst_i = 1'b1;
    sb.delete();
    tick();
    rst_i = 1'b0;
    #1;
    check_bit("rst_valid", result_valid_o, 1'b0);
    check_bit("rst_allow", exec_allow_o, 1'b1);
    check_bit("rst_imm_ready", imm_ready_o, 1'b1);
    tick();

    // Stray exec_done after reset is dropped
    result_ready_i = 1'b1;
    exec_done_i = 1'b1; exec_id_i = 4'd15; exec_data_i = 64'hDEAD;
    #1;
    check_bit("stray_valid", result_valid_o, 1'b0);
    tick();
    clear_inputs();
    #1;
    check_bit("stray_after_valid", result_valid_o, 1'b0);
    check_bit("stray_after_allow", exec_allow_o, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      exec_start_i = 1'b1;
      #1;
      check_bit("stray_credit_allow", exec_allow_o, 1'b1);
      tick();
    end
    exec_start_i = 1'b0;
    #1;
    check_bit("stray_credit_full", exec_allow_o, 1'b0);
    tick();

    #1;
    check_val("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
